// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle sequencer and the RV32I datapath.
// The master is the sequencer; the slave is the datapath/memory side.
interface multicycle_control_if;
   logic [8:0] instr_class;
   logic [2:0] funct3;
   logic       branch_taken;
   logic [1:0] addr_lo;
   logic       mem_ready;

   logic       mem_req;
   logic       mem_we;
   logic       mem_addr_sel;
   logic       ir_load;
   logic       mdr_load;
   logic       alu_a_sel;
   logic       alu_b_sel;
   logic       alu_use_funct;
   logic       reg_we;
   logic [1:0] wb_sel;
   logic       pc_load;
   logic [1:0] pc_sel;
   logic       instr_retired;
   logic       trap;
   logic [1:0] trap_cause;

   modport master (
      input  instr_class, funct3, branch_taken, addr_lo, mem_ready,
      output mem_req, mem_we, mem_addr_sel, ir_load, mdr_load,
             alu_a_sel, alu_b_sel, alu_use_funct, reg_we, wb_sel,
             pc_load, pc_sel, instr_retired, trap, trap_cause
   );

   modport slave (
      output instr_class, funct3, branch_taken, addr_lo, mem_ready,
      input  mem_req, mem_we, mem_addr_sel, ir_load, mdr_load,
             alu_a_sel, alu_b_sel, alu_use_funct, reg_we, wb_sel,
             pc_load, pc_sel, instr_retired, trap, trap_cause
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: fetch/decode/execute/memory/writeback over a shared
// memory port, with illegal-instruction, misalignment and memory-timeout traps.
//
//   state  | meaning
//   IDLE   | post-reset, all outputs quiet, fetch next cycle
//   FETCH  | instruction read from PC, wait for mem_ready
//   DECODE | latch class/funct3, reject illegal encodings
//   EXEC   | ALU work; branches finish here, loads/stores check alignment
//   MEM    | data access at ALU address, wait for mem_ready
//   WB     | register write and PC update
//   TRAP   | parked until reset, cause held
module multicycle_control #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic                  clk,
   input logic                  rst_n,
   multicycle_control_if.master bus
);
   localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   localparam int C_R = 0, C_I = 1, C_IM = 2, C_S = 3, C_B = 4,
                  C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8;

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
   } state_t;

   state_t      state_q, state_d;
   logic [8:0]  cls_q, cls_d;
   logic [1:0]  f3_q, f3_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]  cause_q, cause_d;

   logic        one_hot, misaligned, to_hit, is_ls;
   logic        alu_a_c, alu_b_c, alu_fn_c;
   logic        unused_f3;

   logic       mem_req, mem_we, mem_addr_sel, ir_load, mdr_load;
   logic       alu_a_sel, alu_b_sel, alu_use_funct, reg_we, pc_load, instr_retired;
   logic [1:0] wb_sel, pc_sel;

   assign unused_f3 = bus.funct3[2];
   assign one_hot   = (bus.instr_class != 9'd0) &&
                      ((bus.instr_class & (bus.instr_class - 9'd1)) == 9'd0);
   assign is_ls     = cls_q[C_IM] | cls_q[C_S];
   assign to_hit    = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

   always_comb begin
      misaligned = 1'b0;
      case (f3_q)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = bus.addr_lo[0];
         2'b10:   misaligned = |bus.addr_lo;
         default: misaligned = 1'b1;
      endcase
   end

   // ALU operand selects per class, shared by EXEC and the following MEM/WB cycle.
   assign alu_a_c  = cls_q[C_AUIPC] | cls_q[C_JAL];
   assign alu_b_c  = cls_q[C_I] | cls_q[C_IM] | cls_q[C_S] | cls_q[C_AUIPC] |
                     cls_q[C_JAL] | cls_q[C_JALR];
   assign alu_fn_c = cls_q[C_R] | cls_q[C_I] | cls_q[C_B];

   // Counter restarts whenever the port is idle or an access completes.
   assign cnt_d = (mem_req && !bus.mem_ready) ? cnt_q + 1'b1 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cls_q   <= '0;
         f3_q    <= '0;
         cnt_q   <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         f3_q    <= f3_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      f3_d    = f3_q;
      cause_d = cause_q;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: begin
            if (bus.mem_ready) begin
               state_d = DECODE;
            end else if (to_hit) begin
               state_d = TRAP;
               cause_d = 2'd2;
            end
         end
         DECODE: begin
            cls_d = bus.instr_class;
            f3_d  = bus.funct3[1:0];
            if (!one_hot) begin
               state_d = TRAP;
               cause_d = 2'd1;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cls_q[C_B]) begin
               state_d = FETCH;
            end else if (is_ls) begin
               if (misaligned) begin
                  state_d = TRAP;
                  cause_d = 2'd3;
               end else begin
                  state_d = MEM;
               end
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            if (bus.mem_ready) begin
               state_d = cls_q[C_S] ? FETCH : WB;
            end else if (to_hit) begin
               state_d = TRAP;
               cause_d = 2'd2;
            end
         end
         WB:      state_d = FETCH;
         TRAP:    state_d = TRAP;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 1'b0;
      ir_load       = 1'b0;
      mdr_load      = 1'b0;
      alu_a_sel     = 1'b0;
      alu_b_sel     = 1'b0;
      alu_use_funct = 1'b0;
      reg_we        = 1'b0;
      wb_sel        = 2'd0;
      pc_load       = 1'b0;
      pc_sel        = 2'd0;
      instr_retired = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            ir_load = bus.mem_ready;
         end
         EXEC: begin
            alu_a_sel     = alu_a_c;
            alu_b_sel     = alu_b_c;
            alu_use_funct = alu_fn_c;
            if (cls_q[C_B]) begin
               pc_load       = 1'b1;
               pc_sel        = bus.branch_taken ? 2'd1 : 2'd0;
               instr_retired = 1'b1;
            end
         end
         MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = cls_q[C_S];
            alu_a_sel    = alu_a_c;
            alu_b_sel    = alu_b_c;
            if (bus.mem_ready) begin
               if (cls_q[C_S]) begin
                  pc_load       = 1'b1;
                  instr_retired = 1'b1;
               end else begin
                  mdr_load = 1'b1;
               end
            end
         end
         WB: begin
            alu_a_sel     = alu_a_c;
            alu_b_sel     = alu_b_c;
            alu_use_funct = alu_fn_c;
            reg_we        = 1'b1;
            pc_load       = 1'b1;
            instr_retired = 1'b1;
            if (cls_q[C_IM])                      wb_sel = 2'd1;
            else if (cls_q[C_JAL] | cls_q[C_JALR]) wb_sel = 2'd2;
            else if (cls_q[C_LUI])                wb_sel = 2'd3;
            if (cls_q[C_JAL])       pc_sel = 2'd1;
            else if (cls_q[C_JALR]) pc_sel = 2'd2;
         end
         default: ;
      endcase
   end

   assign bus.mem_req       = mem_req;
   assign bus.mem_we        = mem_we;
   assign bus.mem_addr_sel  = mem_addr_sel;
   assign bus.ir_load       = ir_load;
   assign bus.mdr_load      = mdr_load;
   assign bus.alu_a_sel     = alu_a_sel;
   assign bus.alu_b_sel     = alu_b_sel;
   assign bus.alu_use_funct = alu_use_funct;
   assign bus.reg_we        = reg_we;
   assign bus.wb_sel        = wb_sel;
   assign bus.pc_load       = pc_load;
   assign bus.pc_sel        = pc_sel;
   assign bus.instr_retired = instr_retired;
   assign bus.trap          = (state_q == TRAP);
   assign bus.trap_cause    = cause_q;
endmodule
